// File: rtl/matvec_accumulate_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : matvec_accumulate_sequencer
// Purpose : Runs a matrix-vector product one row at a time through a shared
//           stream accumulator. For each row it reads LENGTH weight/vector
//           pairs, streams their truncated products to the accumulator, waits
//           for the row sum and writes it to the result buffer.
// Ports   : clk, rst_n               - clock, async active-low reset
//           start, rows, busy, done  - host job handshake
//           w_rd_en/w_addr/w_data    - weight RAM read port (1-cycle latency)
//           x_rd_en/x_addr/x_data    - vector RAM read port (1-cycle latency)
//           acc_valid/acc_data       - product stream to accumulator
//           acc_out_valid/acc_result - accumulator row sum
//           res_wr_en/res_addr/res_data - result RAM write port
// Revision: 1.0 - initial release
// ============================================================================
module matvec_accumulate_sequencer #(
    parameter int BITS     = 8,
    parameter int LENGTH   = 10,
    parameter int MAX_ROWS = 16,
    parameter int AW       = 8,
    localparam int c_RW    = $clog2(MAX_ROWS + 1),
    localparam int c_RAW   = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
    localparam int c_XW    = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [c_RW-1:0]  rows,
    output logic             busy,
    output logic             done,
    output logic             w_rd_en,
    output logic [AW-1:0]    w_addr,
    input  logic [BITS-1:0]  w_data,
    output logic             x_rd_en,
    output logic [c_XW-1:0]  x_addr,
    input  logic [BITS-1:0]  x_data,
    output logic             acc_valid,
    output logic [BITS-1:0]  acc_data,
    input  logic             acc_out_valid,
    input  logic [BITS-1:0]  acc_result,
    output logic             res_wr_en,
    output logic [c_RAW-1:0] res_addr,
    output logic [BITS-1:0]  res_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_DRAIN = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_RAW-1:0]   r_row;
    logic [c_RAW-1:0]   r_last;     // index of the final row of the job
    logic               r_v1;       // read enable delayed one cycle (data valid)
    logic [c_RW-1:0]    w_rows_clamped;
    logic [2*BITS-1:0]  w_prod;

    assign w_rows_clamped = (rows > c_RW'(MAX_ROWS)) ? c_RW'(MAX_ROWS) : rows;
    assign w_prod         = w_data * x_data;

    // Both memories are read in lockstep; x_addr doubles as the k counter.
    assign x_rd_en = w_rd_en;

    // Product pipeline: read at t, data at t+1, registered product at t+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1      <= 1'b0;
            acc_valid <= 1'b0;
            acc_data  <= '0;
        end else begin
            r_v1      <= w_rd_en;
            acc_valid <= r_v1;
            acc_data  <= r_v1 ? w_prod[BITS-1:0] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_last    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_rd_en   <= 1'b0;
            w_addr    <= '0;
            x_addr    <= '0;
            res_wr_en <= 1'b0;
            res_addr  <= '0;
            res_data  <= '0;
        end else begin
            done      <= 1'b0;
            res_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (rows == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_last  <= c_RAW'(w_rows_clamped - c_RW'(1));
                            r_row   <= '0;
                            w_addr  <= '0;
                            x_addr  <= '0;
                            w_rd_en <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (x_addr == c_XW'(LENGTH - 1)) begin
                        // w_addr is left on the last element; the next row
                        // starts at w_addr + 1.
                        w_rd_en <= 1'b0;
                        x_addr  <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        x_addr <= x_addr + c_XW'(1);
                        w_addr <= w_addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    // Enter WAIT exactly when the accumulator has seen
                    // in_valid fall, so its one-cycle result strobe is caught.
                    if (!r_v1 && !acc_valid) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (acc_out_valid) begin
                        res_data <= acc_result;
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    res_wr_en <= 1'b1;
                    res_addr  <= r_row;
                    if (r_row == r_last) begin
                        r_state <= S_FIN;
                    end else begin
                        r_row   <= r_row + c_RAW'(1);
                        w_addr  <= w_addr + AW'(1);
                        w_rd_en <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matvec_accumulate_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_matvec_accumulate_sequencer
// Purpose : Directed bench for matvec_accumulate_sequencer (LENGTH=4). Models
//           the weight/vector RAMs and the stream accumulator, logs DUT
//           activity and compares against hand-computed values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_matvec_accumulate_sequencer;

    localparam int BITS = 8, LENGTH = 4, MAX_ROWS = 16, AW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] rows;
    logic       busy, done, w_rd_en, x_rd_en, acc_valid, res_wr_en;
    logic [7:0] w_addr, w_data, x_data, acc_data, acc_result, res_data;
    logic [1:0] x_addr;
    logic [3:0] res_addr;
    logic       acc_out_valid;

    matvec_accumulate_sequencer #(
        .BITS(BITS), .LENGTH(LENGTH), .MAX_ROWS(MAX_ROWS), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rows(rows),
        .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .x_rd_en(x_rd_en), .x_addr(x_addr), .x_data(x_data),
        .acc_valid(acc_valid), .acc_data(acc_data),
        .acc_out_valid(acc_out_valid), .acc_result(acc_result),
        .res_wr_en(res_wr_en), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    logic [7:0] wmem [256];
    logic [7:0] xmem [4];
    logic [7:0] acc_sum = '0;
    logic       acc_prev = 1'b0;

    initial begin
        w_data = '0; x_data = '0; acc_out_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (w_rd_en) w_data <= wmem[w_addr];
        if (x_rd_en) x_data <= xmem[x_addr];
    end

    // Stream accumulator: sums while in_valid, strobes the sum one cycle
    // after in_valid falls, restarts on the next rising edge.
    always @(posedge clk) begin
        acc_prev      <= acc_valid;
        acc_out_valid <= acc_prev && !acc_valid;
        if (acc_valid) acc_sum <= (acc_valid && !acc_prev) ? acc_data : acc_sum + acc_data;
    end
    assign acc_result = acc_sum;

    // ---------------- activity logs ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_addr_q[$], wr_data_q[$], rd_addr_q[$], av_data_q[$], run_q[$];
    int ndone, nbusy, first_rd, first_wr, done_cyc, min_gap, low_run, run_len;
    int xerr = 0, xaerr = 0, st_cyc;
    bit seen_hi, prev_av;

    always @(negedge clk) begin
        if (w_rd_en !== x_rd_en) xerr++;
        if (w_rd_en && (x_addr !== 2'(w_addr % 4))) xaerr++;
        if (w_rd_en) begin
            rd_addr_q.push_back(int'(w_addr));
            if (first_rd < 0) first_rd = cyc;
        end
        if (res_wr_en) begin
            wr_addr_q.push_back(int'(res_addr));
            wr_data_q.push_back(int'(res_data));
            if (first_wr < 0) first_wr = cyc;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (busy) nbusy++;
        if (acc_valid) begin
            av_data_q.push_back(int'(acc_data));
            if (!prev_av && seen_hi && low_run < min_gap) min_gap = low_run;
            seen_hi = 1'b1;
            low_run = 0;
            run_len++;
        end else begin
            if (prev_av) run_q.push_back(run_len);
            run_len = 0;
            low_run++;
        end
        prev_av = acc_valid;
    end

    // ---------------- checking ----------------
    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        wr_addr_q = {}; wr_data_q = {}; rd_addr_q = {}; av_data_q = {}; run_q = {};
        ndone = 0; nbusy = 0; first_rd = -1; first_wr = -1; done_cyc = -1;
        min_gap = 1000; low_run = 0; run_len = 0; seen_hi = 1'b0;
    endtask

    task automatic start_pulse(input int r);
        @(posedge clk); #1;
        start = 1'b1; rows = 5'(r); st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 600 && ndone == 0; i++) @(negedge clk);
        check({tag, "_done_seen"}, 32'(ndone > 0), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_job(input int r, input string tag);
        clear_logs();
        start_pulse(r);
        wait_done(tag);
    endtask

    task automatic load_three_rows();
        for (int k = 0; k < 4; k++) begin
            wmem[k] = 8'd1; wmem[4 + k] = 8'd2; wmem[8 + k] = (k % 2 == 1) ? 8'd5 : 8'd0;
            xmem[k] = 8'd3;
        end
    endtask

    task automatic check_three_rows(input string tag);
        check({tag, "_nwr"}, wr_addr_q.size(), 3);
        check({tag, "_a0"}, qget(wr_addr_q, 0), 0);
        check({tag, "_d0"}, qget(wr_data_q, 0), 12);
        check({tag, "_a1"}, qget(wr_addr_q, 1), 1);
        check({tag, "_d1"}, qget(wr_data_q, 1), 24);
        check({tag, "_a2"}, qget(wr_addr_q, 2), 2);
        check({tag, "_d2"}, qget(wr_data_q, 2), 30);
        check({tag, "_ndone"}, ndone, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rows = '0;
        for (int i = 0; i < 256; i++) wmem[i] = 8'(i);
        clear_logs();
        repeat (3) @(posedge clk); #1;
        check("reset_outs", 32'(|{busy, done, w_rd_en, x_rd_en, acc_valid, res_wr_en,
                                 w_addr, x_addr, acc_data, res_addr, res_data}), 0);
        rst_n = 1'b1;

        // Single row: 1,2,3,4 . 1,1,1,1 = 10
        for (int k = 0; k < 4; k++) begin wmem[k] = 8'(k + 1); xmem[k] = 8'd1; end
        run_job(1, "one");
        check("one_nav", av_data_q.size(), 4);
        for (int k = 0; k < 4; k++) check("one_accdata", qget(av_data_q, k), k + 1);
        check("one_nwr", wr_addr_q.size(), 1);
        check("one_addr", qget(wr_addr_q, 0), 0);
        check("one_data", qget(wr_data_q, 0), 10);
        check("one_latency", first_wr - first_rd, 9);
        check("one_done_after_wr", done_cyc - first_wr, 1);
        check("one_ndone", ndone, 1);

        // Three rows
        load_three_rows();
        run_job(3, "three");
        check_three_rows("three");
        check("three_nrd", rd_addr_q.size(), 12);
        for (int i = 0; i < 12; i++) check("three_waddr", qget(rd_addr_q, i), i);
        check("three_gap_ge3", 32'(min_gap >= 3), 1);
        check("three_nruns", run_q.size(), 3);
        for (int i = 0; i < 3; i++) check("three_runlen", qget(run_q, i), 4);

        // Overflow: 16*16 truncates to 0
        for (int k = 0; k < 4; k++) begin wmem[k] = 8'd16; xmem[k] = 8'd16; end
        run_job(1, "ovf0");
        check("ovf0_prod", qget(av_data_q, 0), 0);
        check("ovf0_data", qget(wr_data_q, 0), 0);
        wmem[0] = 8'd200; wmem[1] = 8'd100; wmem[2] = 8'd0; wmem[3] = 8'd0;
        xmem[0] = 8'd1; xmem[1] = 8'd1; xmem[2] = 8'd0; xmem[3] = 8'd0;
        run_job(1, "ovf44");
        check("ovf44_data", qget(wr_data_q, 0), 44);

        // rows = 0
        run_job(0, "zero");
        check("zero_nrd", rd_addr_q.size(), 0);
        check("zero_nwr", wr_addr_q.size(), 0);
        check("zero_done_lat", done_cyc - st_cyc, 2);
        check("zero_nbusy", nbusy, 1);

        // start pulsed mid-job is ignored
        load_three_rows();
        clear_logs();
        start_pulse(3);
        repeat (6) @(posedge clk);
        start_pulse(2);
        repeat (12) @(posedge clk);
        start_pulse(1);
        wait_done("mid");
        repeat (30) @(negedge clk);
        check_three_rows("mid");

        // Reset during row 1 issue of a 3-row job
        clear_logs();
        start_pulse(3);
        for (int i = 0; i < 100 && !(w_rd_en && w_addr == 8'd5); i++) @(negedge clk);
        check("rst_reached_row1", 32'(w_rd_en && w_addr == 8'd5), 1);
        #2 rst_n = 1'b0;
        #1 check("rst_outs_zero", 32'(|{busy, done, w_rd_en, x_rd_en, acc_valid, res_wr_en,
                                       w_addr, x_addr, acc_data, res_addr, res_data}), 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_nwr", wr_addr_q.size(), 1);
        check("rst_ndone", ndone, 0);
        run_job(3, "after_rst");
        check_three_rows("after_rst");

        // rows above MAX_ROWS clamp to MAX_ROWS
        run_job(20, "clamp");
        check("clamp_nwr", wr_addr_q.size(), 16);
        check("clamp_last_addr", qget(wr_addr_q, 15), 15);

        check("x_rd_en_tracks_w", xerr, 0);
        check("x_addr_is_k", xaerr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matvec_accumulate_sequencer.md
Name: matvec_accumulate_sequencer

Overview:
- Sequences a matrix-vector product through one shared stream accumulator. The accumulator sums BITS-wide elements while its in_valid is high and emits the sum one cycle after in_valid falls.
- For each row, the block reads LENGTH weight/vector element pairs from two synchronous memories and multiplies each pair. It streams the truncated products to the accumulator, captures the row sum and writes it to a result buffer.
- It sits between the weight/vector RAMs, the accumulator and the result RAM, under a host start/done handshake.

Parameters:
- BITS, 8, element, product and result width (all arithmetic modulo 2^BITS).
- LENGTH, 10, elements per row (dot-product length), >= 1.
- MAX_ROWS, 16, maximum rows per job, >= 1.
- AW, 8, weight memory address width; must satisfy 2^AW >= MAX_ROWS*LENGTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle job request; sampled only in IDLE.
- rows  input  $clog2(MAX_ROWS+1)  row count, captured at accepted start.
- busy  output  1  high from the cycle after accepted start until done.
- done  output  1  one-cycle pulse at job completion.
- w_rd_en  output  1  weight memory read enable.
- w_addr  output  AW  weight address = row*LENGTH + k.
- w_data  input  BITS  weight read data, valid 1 cycle after w_rd_en.
- x_rd_en  output  1  vector memory read enable (equal to w_rd_en).
- x_addr  output  $clog2(LENGTH)  vector address = k.
- x_data  input  BITS  vector read data, valid 1 cycle after x_rd_en.
- acc_valid  output  1  to accumulator in_valid.
- acc_data  output  BITS  to accumulator a, product[BITS-1:0].
- acc_out_valid  input  1  accumulator result strobe.
- acc_result  input  BITS  accumulator sum.
- res_wr_en  output  1  result RAM write strobe.
- res_addr  output  $clog2(MAX_ROWS)  result address = row.
- res_data  output  BITS  row sum.

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM to IDLE, counters 0. Any job in progress is abandoned; no res_wr_en or done follows.
- States: IDLE, ISSUE, DRAIN, WAIT, WRITE, FIN.
- IDLE:
  - start=1 with rows>0: latch rows, row=0, k=0, go to ISSUE.
  - start=1 with rows=0: go to FIN; done pulses next cycle and no memory reads occur.
  - start while not IDLE is ignored.
- ISSUE:
  - w_rd_en=x_rd_en=1 with the current addresses, k increments each cycle.
  - After k=LENGTH-1 is issued, go to DRAIN; k resets to 0.
  - Exactly LENGTH consecutive read cycles per row, with no gaps.
- Product pipeline:
  - Read at cycle t, data at t+1, product registered at t+2.
  - acc_valid = read enable delayed by 2 cycles; acc_data = (w_data*x_data) truncated to BITS, 0 when acc_valid=0.
  - acc_valid is high for exactly LENGTH contiguous cycles per row.
- DRAIN: wait until the pipeline is empty (acc_valid has fallen), then go to WAIT.
- WAIT: hold until acc_out_valid=1, then register acc_result into res_data and go to WRITE.
- WRITE:
  - res_wr_en=1 for one cycle, res_addr=row.
  - If row==rows-1, go to FIN; else row++ and go to ISSUE.
  - This guarantees acc_valid is low for at least 3 cycles between rows, so the accumulator always sees a falling edge and clears.
- FIN: done=1 for one cycle, busy drops the same cycle, then return to IDLE.
- Per-row latency, from first read to res_wr_en: LENGTH+5 cycles, given accumulator output 1 cycle after in_valid falls.
- acc_out_valid outside WAIT is ignored.
- rows > MAX_ROWS is clamped to MAX_ROWS.
- No timeout: a missing acc_out_valid leaves the block in WAIT until reset.

Test Plan:
- BITS=8, LENGTH=4, rows=1, W row0=1,2,3,4, X=1,1,1,1 -> acc_valid high 4 cycles with data 1,2,3,4. One res_wr_en with addr 0, data 10. done 1 cycle later.
- rows=3, W rows {1,1,1,1},{2,2,2,2},{0,5,0,5}, X=3,3,3,3 -> writes (0,12),(1,24),(2,30). acc_valid low >= 3 cycles between rows. w_addr 0..11 in order.
- Overflow, W=16,16,16,16 and X=16,16,16,16 -> each product 256 truncates to 0 and the result is 0. Separately, W=200,100,0,0 and X=1,1,0,0 -> 300 mod 256 = 44.
- rows=0 start -> no w_rd_en, no res_wr_en, done pulse 2 cycles after start, busy low except the FIN cycle.
- start pulsed again mid-job -> ignored. Results and done count match a single job.
- rst_n low during ISSUE of row 1 of a 3-row job -> all outputs 0 immediately. No further res_wr_en. A new start afterwards runs a full correct job.
